div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : Iterative restoring divider for the EXE stage. Produces one
//               quotient bit per cycle, supports signed (DIV) and unsigned
//               (DIVU) operation, divide-by-zero shortcut, pipeline stall
//               request and exception flush.
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl #(
  parameter int DIV_W = 32
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [DIV_W-1:0] div_opdata1,
  input  logic [DIV_W-1:0] div_opdata2,
  input  logic             flush,
  output logic             stallreq_div,
  output logic             div_ready,
  output logic [DIV_W-1:0] div_quo,
  output logic [DIV_W-1:0] div_rem
);

  localparam int CNT_W = (DIV_W > 1) ? $clog2(DIV_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;

  // Shift register: starts as |dividend|, quotient bits enter at the bottom.
  logic [DIV_W-1:0] dvd_quo;
  logic [DIV_W-1:0] dvs_abs;
  logic [DIV_W-1:0] part_rem;
  logic             sign_dvd;
  logic             sign_dvs;
  logic             sgn_mode;

  logic             start_ok;
  logic             op1_neg;
  logic             op2_neg;
  logic [DIV_W-1:0] op1_abs;
  logic [DIV_W-1:0] op2_abs;

  logic [DIV_W:0]   trial;
  logic [DIV_W:0]   diff;
  logic             fits;
  logic [DIV_W-1:0] step_rem;
  logic [DIV_W-1:0] step_quo;
  logic             neg_quo;
  logic             neg_rem;
  logic [DIV_W-1:0] fin_quo;
  logic [DIV_W-1:0] fin_rem;

  assign start_ok = div_start & ~flush;
  assign op1_neg  = div_signed & div_opdata1[DIV_W-1];
  assign op2_neg  = div_signed & div_opdata2[DIV_W-1];
  assign op1_abs  = op1_neg ? (~div_opdata1 + 1'b1) : div_opdata1;
  assign op2_abs  = op2_neg ? (~div_opdata2 + 1'b1) : div_opdata2;

  // One restoring step: bring down the next dividend bit and subtract the
  // divisor if it fits. A borrow out of the extra MSB means it did not fit.
  assign trial    = {part_rem, dvd_quo[DIV_W-1]};
  assign diff     = trial - {1'b0, dvs_abs};
  assign fits     = ~diff[DIV_W];
  assign step_rem = fits ? diff[DIV_W-1:0] : trial[DIV_W-1:0];
  assign step_quo = {dvd_quo[DIV_W-2:0], fits};

  // Sign correction uses only the flags captured at start time.
  assign neg_quo  = sgn_mode & (sign_dvd ^ sign_dvs);
  assign neg_rem  = sgn_mode & sign_dvd;
  assign fin_quo  = neg_quo ? (~step_quo + 1'b1) : step_quo;
  assign fin_rem  = neg_rem ? (~step_rem + 1'b1) : step_rem;

  // State register.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides start and completion.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_start) begin
            state_nxt = (div_opdata2 == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: state_nxt = S_DONE;
        S_ON: begin
          if (cnt == CNT_LAST) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Stall and ready outputs; stall is held low while reset is asserted.
  always_comb begin
    stallreq_div = ~cpu_rst & (((state == S_IDLE) & start_ok) |
                               (state == S_BYZERO) | (state == S_ON));
    div_ready    = (state == S_DONE) & ~flush;
  end

  // Operand capture, iteration datapath and result registers. Results only
  // change on the edge that enters DONE, so they hold between divisions.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      cnt      <= '0;
      dvd_quo  <= '0;
      dvs_abs  <= '0;
      part_rem <= '0;
      sign_dvd <= 1'b0;
      sign_dvs <= 1'b0;
      sgn_mode <= 1'b0;
      div_quo  <= '0;
      div_rem  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            dvd_quo  <= op1_abs;
            dvs_abs  <= op2_abs;
            sign_dvd <= div_opdata1[DIV_W-1];
            sign_dvs <= div_opdata2[DIV_W-1];
            sgn_mode <= div_signed;
            cnt      <= '0;
            part_rem <= '0;
          end
        end
        S_BYZERO: begin
          if (!flush) begin
            div_quo <= '0;
            div_rem <= '0;
          end
        end
        S_ON: begin
          if (!flush) begin
            dvd_quo  <= step_quo;
            part_rem <= step_rem;
            cnt      <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              div_quo <= fin_quo;
              div_rem <= fin_rem;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ctrl
// Description : Self-checking bench for div_ctrl. A cycle-level reference
//               model tracks when results are due and what they are; directed
//               vectors with hand-computed literals pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

  localparam int W = 32;

  logic         cpu_clk_50M = 1'b0;
  logic         cpu_rst = 1'b0;
  logic         div_start = 1'b0;
  logic         div_signed = 1'b0;
  logic [W-1:0] div_opdata1 = '0;
  logic [W-1:0] div_opdata2 = '0;
  logic         flush = 1'b0;
  logic         stallreq_div;
  logic         div_ready;
  logic [W-1:0] div_quo;
  logic [W-1:0] div_rem;

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;

  div_ctrl #(.DIV_W(W)) dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst      (cpu_rst),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_opdata1  (div_opdata1),
    .div_opdata2  (div_opdata2),
    .flush        (flush),
    .stallreq_div (stallreq_div),
    .div_ready    (div_ready),
    .div_quo      (div_quo),
    .div_rem      (div_rem)
  );

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference arithmetic: plain integer division on wide signed values.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint sa, sb, lq, lr;
    logic [W-1:0] q, r;
    if (b == '0) return '0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Cycle model: a started division completes m_len cycles after start.
  bit           m_busy = 1'b0;
  int           m_cyc  = 0;
  int           m_len  = 0;
  logic [W-1:0] m_pend_q = '0, m_pend_r = '0;
  logic [W-1:0] m_out_q = '0, m_out_r = '0;

  always @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      m_busy  = 1'b0;
      m_out_q = '0;
      m_out_r = '0;
    end else if (m_busy) begin
      if (flush || m_cyc == m_len) begin
        m_busy = 1'b0;
      end else begin
        m_cyc++;
        if (m_cyc == m_len) begin
          m_out_q = m_pend_q;
          m_out_r = m_pend_r;
        end
      end
    end else if (div_start && !flush) begin
      m_busy = 1'b1;
      m_cyc  = 1;
      m_len  = (div_opdata2 == '0) ? 2 : W + 1;
      {m_pend_q, m_pend_r} = ref_div(div_opdata1, div_opdata2, div_signed);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge cpu_clk_50M) begin
    if (chk_en) begin
      chk("m_stall", {31'd0, stallreq_div},
          {31'd0, !cpu_rst && ((!m_busy && div_start && !flush) || (m_busy && m_cyc < m_len))});
      chk("m_ready", {31'd0, div_ready}, {31'd0, m_busy && m_cyc == m_len && !flush});
      chk("m_quo", div_quo, m_out_q);
      chk("m_rem", div_rem, m_out_r);
    end
  end

  // Called at posedge+1; the current cycle is cycle 0 of the division.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input int lat);
    bit got = 1'b0;
    div_start   = 1'b1;
    div_opdata1 = a;
    div_opdata2 = b;
    div_signed  = s;
    for (int c = 0; c <= 40 && !got; c++) begin
      @(negedge cpu_clk_50M);
      if (div_ready) begin
        chk("latency", 32'(c), 32'(lat));
        chk("quo", div_quo, eq);
        chk("rem", div_rem, er);
        chk("stall_done", {31'd0, stallreq_div}, 32'd0);
        got = 1'b1;
      end else begin
        chk("stall_busy", {31'd0, stallreq_div}, 32'd1);
        @(posedge cpu_clk_50M);
        #1;
        // Operands change after capture; results must not depend on them.
        div_opdata1 = $urandom;
        div_opdata2 = $urandom;
        div_signed  = 1'($urandom);
      end
    end
    if (!got) begin
      vectors++;
      fails++;
      $display("FAIL timeout: got no div_ready expected pulse at cycle %0d", lat);
    end
    @(posedge cpu_clk_50M);
    #1;
    div_start = 1'b0;
  endtask

  initial begin
    int pulses;
    #2 cpu_rst = 1'b1;
    #1;
    chk("rst_stall", {31'd0, stallreq_div}, 32'd0);
    chk("rst_ready", {31'd0, div_ready}, 32'd0);
    chk("rst_quo", div_quo, 32'h0);
    chk("rst_rem", div_rem, 32'h0);
    @(posedge cpu_clk_50M);
    @(posedge cpu_clk_50M);
    #1;
    cpu_rst = 1'b0;
    chk_en  = 1'b1;

    run_div(32'd100, 32'd7, 1'b1, 32'h0000000E, 32'h00000002, 33);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    run_div(32'hFFFFFFFF, 32'd2, 1'b0, 32'h7FFFFFFF, 32'h00000001, 33);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h00000001, 33);
    run_div(32'd5, 32'd0, 1'b1, 32'h0, 32'h0, 2);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000, 33);
    // Back-to-back with start held through DONE: second run needs full latency.
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 33);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 33);

    // Flush during cycle 10 of a division.
    div_start   = 1'b1;
    div_opdata1 = 32'd1000;
    div_opdata2 = 32'd3;
    div_signed  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge cpu_clk_50M);
      #1;
    end
    flush = 1'b1;
    @(posedge cpu_clk_50M);
    #1;
    flush     = 1'b0;
    div_start = 1'b0;
    @(negedge cpu_clk_50M);
    chk("flush_stall", {31'd0, stallreq_div}, 32'd0);
    chk("flush_ready", {31'd0, div_ready}, 32'd0);
    chk("flush_quo", div_quo, 32'h80000000);
    chk("flush_rem", div_rem, 32'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge cpu_clk_50M);
      if (div_ready) pulses++;
    end
    chk("flush_no_pulse", 32'(pulses), 32'd0);
    @(posedge cpu_clk_50M);
    #1;

    // Reset pulse mid-division, then a fresh division on the first edge.
    div_start   = 1'b1;
    div_opdata1 = 32'd100;
    div_opdata2 = 32'd7;
    div_signed  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge cpu_clk_50M);
      #1;
    end
    cpu_rst = 1'b1;
    #1;
    chk("arst_stall", {31'd0, stallreq_div}, 32'd0);
    chk("arst_ready", {31'd0, div_ready}, 32'd0);
    chk("arst_quo", div_quo, 32'h0);
    chk("arst_rem", div_rem, 32'h0);
    @(posedge cpu_clk_50M);
    #1;
    cpu_rst = 1'b0;
    run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);
    run_div(32'd0, 32'd5, 1'b1, 32'd0, 32'd0, 33);

    repeat (3) @(posedge cpu_clk_50M);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
